lif_neuron_array: RTL and testbench

Time-multiplexed bank of NUM_NEURONS leaky integrate-and-fire neurons. This is the parametrised, clocked successor of the single combinational neuron datapath. Membrane potentials and refractory counters live in internal register arrays. Weight events are accumulated one per cycle; a timestep command sweeps every neuron (decay, threshold, fire, reset-to-zero, refractory) and streams spike indices out over a valid/ready port. The block sits between the input spike/weight fetch logic and the output spike collector of the SNN accelerator.

---
 rtl/snn_pkg.sv | 23 ++
 rtl/lif_update.sv | 68 ++++++
 rtl/lif_neuron_array.sv | 150 +++++++++++++++
 tb/tb_lif_neuron_array.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the LIF neuron bank: command opcodes, sweep FSM
// states and sign-magnitude weight field helpers.
package snn_pkg;

  // Command opcodes on in_op; also used as the datapath mode select.
  localparam logic OP_ACCUM = 1'b0;
  localparam logic OP_STEP  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Sign-magnitude weights: sign in the MSB, magnitude in the bits below it.
  function automatic int sm_sign_pos(input int w);
    return w - 1;
  endfunction

  function automatic int sm_mag_w(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron datapath shared by weight accumulation and
// the timestep sweep (decay, threshold, fire, refractory handling).
module lif_update
  import snn_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int REFRAC_W = 4
) (
  input  logic [WIDTH-1:0]    vmem_i,
  input  logic [REFRAC_W-1:0] refrac_i,
  input  logic [WIDTH-1:0]    weight_i,
  input  logic                mode_i,
  input  logic [WIDTH-1:0]    beta_i,
  input  logic [WIDTH-1:0]    v_th_i,
  input  logic [REFRAC_W-1:0] refrac_len_i,
  output logic [WIDTH-1:0]    vmem_o,
  output logic [REFRAC_W-1:0] refrac_o,
  output logic                spike_o
);

  localparam int SIGN  = sm_sign_pos(WIDTH);
  localparam int MAG_W = sm_mag_w(WIDTH);

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [MAG_W-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {2'b00, m};
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] floor_sub(input logic [WIDTH-1:0] a,
                                                 input logic [MAG_W-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {2'b00, m};
    return d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] decayed;

  // Keep only the integer part of vmem * beta/2^WIDTH from the full product.
  assign decayed = WIDTH'(({{WIDTH{1'b0}}, vmem_i} * {{WIDTH{1'b0}}, beta_i}) >> WIDTH);

  // Select the next neuron state for either accumulation or timestep update.
  always_comb begin
    vmem_o   = vmem_i;
    refrac_o = refrac_i;
    spike_o  = 1'b0;
    if (mode_i == OP_ACCUM) begin
      // A refractory neuron ignores incoming weight.
      if (refrac_i == '0) begin
        vmem_o = weight_i[SIGN] ? floor_sub(vmem_i, weight_i[MAG_W-1:0])
                                : sat_add(vmem_i, weight_i[MAG_W-1:0]);
      end
    end else begin
      if (refrac_i != '0) begin
        refrac_o = refrac_i - 1'b1;
        vmem_o   = '0;
      end else if (decayed > v_th_i) begin
        spike_o  = 1'b1;
        vmem_o   = '0;
        refrac_o = refrac_len_i;
      end else begin
        vmem_o = decayed;
      end
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons. ACCUM commands
// add one weight per cycle; a STEP command sweeps every neuron once and
// streams spiking indices out through a one-entry valid/ready register.
module lif_neuron_array
  import snn_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = $clog2(NUM_NEURONS),
  parameter int REFRAC_W    = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_op,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic [WIDTH-1:0]    in_weight,
  input  logic [WIDTH-1:0]    beta,
  input  logic [WIDTH-1:0]    v_th,
  input  logic [REFRAC_W-1:0] refrac_len,
  output logic                spike_valid,
  input  logic                spike_ready,
  output logic [IDX_W-1:0]    spike_idx,
  output logic                step_done,
  output logic                busy,
  input  logic [IDX_W-1:0]    dbg_idx,
  output logic [WIDTH-1:0]    dbg_vmem
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                spk_vld_q, spk_vld_d;
  logic [IDX_W-1:0]    spk_idx_q, spk_idx_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    beta_q, vth_q;
  logic [REFRAC_W-1:0] rlen_q;
  logic [WIDTH-1:0]    vmem_q   [NUM_NEURONS];
  logic [REFRAC_W-1:0] refrac_q [NUM_NEURONS];

  logic                sweeping, accept, acc_wr, step_go, adv, last, wr, idx_ok, mode;
  logic [IDX_W-1:0]    cur_idx;
  logic [WIDTH-1:0]    upd_vmem;
  logic [REFRAC_W-1:0] upd_refrac;
  logic                upd_spike;

  // Out-of-range ACCUM targets only exist when the bank is not a power of two.
  if ((2 ** IDX_W) == NUM_NEURONS) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (32'(in_idx) < NUM_NEURONS);
  end

  assign sweeping = (state_q == ST_SWEEP);
  assign cur_idx  = sweeping ? ptr_q : in_idx;
  assign mode     = sweeping ? OP_STEP : OP_ACCUM;

  lif_update #(
    .WIDTH    (WIDTH),
    .REFRAC_W (REFRAC_W)
  ) u_update (
    .vmem_i       (vmem_q[cur_idx]),
    .refrac_i     (refrac_q[cur_idx]),
    .weight_i     (in_weight),
    .mode_i       (mode),
    .beta_i       (beta_q),
    .v_th_i       (vth_q),
    .refrac_len_i (rlen_q),
    .vmem_o       (upd_vmem),
    .refrac_o     (upd_refrac),
    .spike_o      (upd_spike)
  );

  // Command acceptance, sweep advance (stalling a spiking neuron while the
  // spike register is full and not draining) and next control state.
  always_comb begin
    accept  = in_valid & ~sweeping;
    acc_wr  = accept & (in_op == OP_ACCUM) & idx_ok;
    step_go = accept & (in_op == OP_STEP);
    adv     = sweeping & (~upd_spike | ~spk_vld_q | spike_ready);
    last    = (ptr_q == IDX_W'(NUM_NEURONS - 1));
    wr      = acc_wr | adv;

    state_d   = state_q;
    ptr_d     = ptr_q;
    spk_vld_d = spk_vld_q & ~spike_ready;
    spk_idx_d = spk_idx_q;
    done_d    = adv & last;

    if (step_go) begin
      state_d = ST_SWEEP;
      ptr_d   = '0;
    end else if (adv) begin
      if (last) state_d = ST_IDLE;
      else      ptr_d   = ptr_q + 1'b1;
    end

    if (adv & upd_spike) begin
      spk_vld_d = 1'b1;
      spk_idx_d = ptr_q;
    end
  end

  // Control registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      spk_vld_q <= 1'b0;
      spk_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      spk_vld_q <= spk_vld_d;
      spk_idx_q <= spk_idx_d;
      done_q    <= done_d;
    end
  end

  // Sweep parameters are captured once per STEP so mid-sweep changes are ignored.
  always_ff @(posedge wb_clk_i) begin
    if (step_go) begin
      beta_q <= beta;
      vth_q  <= v_th;
      rlen_q <= refrac_len;
    end
  end

  // Neuron state arrays: cleared on reset, written by ACCUM or sweep advance.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        vmem_q[n]   <= '0;
        refrac_q[n] <= '0;
      end
    end else if (wr) begin
      vmem_q[cur_idx]   <= upd_vmem;
      refrac_q[cur_idx] <= upd_refrac;
    end
  end

  assign in_ready    = ~sweeping;
  assign busy        = sweeping;
  assign spike_valid = spk_vld_q;
  assign spike_idx   = spk_idx_q;
  assign step_done   = done_q;
  assign dbg_vmem    = vmem_q[dbg_idx];

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed plus randomized bench for lif_neuron_array with a behavioural
// model of the neuron bank (integer arithmetic over plain arrays).
module tb_lif_neuron_array;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_op;
  logic [IW-1:0] in_idx;
  logic [W-1:0]  in_weight, beta, v_th;
  logic [RW-1:0] refrac_len;
  logic          spike_valid, spike_ready;
  logic [IW-1:0] spike_idx;
  logic          step_done, busy;
  logic [IW-1:0] dbg_idx;
  logic [W-1:0]  dbg_vmem;

  lif_neuron_array #(.WIDTH(W), .NUM_NEURONS(N), .IDX_W(IW), .REFRAC_W(RW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_idx      (in_idx),
    .in_weight   (in_weight),
    .beta        (beta),
    .v_th        (v_th),
    .refrac_len  (refrac_len),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_idx   (spike_idx),
    .step_done   (step_done),
    .busy        (busy),
    .dbg_idx     (dbg_idx),
    .dbg_vmem    (dbg_vmem)
  );

  always #50 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int m_vm[N];
  int m_rc[N];
  int exp_q[$];
  int got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int n = 0; n < N; n++) begin
      m_vm[n] = 0;
      m_rc[n] = 0;
    end
  endtask

  task automatic m_accum(input int idx, input int w);
    int mag;
    mag = w % 128;
    if (idx < N && m_rc[idx] == 0) begin
      if (w >= 128) m_vm[idx] = (m_vm[idx] - mag < 0) ? 0 : m_vm[idx] - mag;
      else          m_vm[idx] = (m_vm[idx] + mag > 255) ? 255 : m_vm[idx] + mag;
    end
  endtask

  task automatic m_step(input int b, input int th, input int rl);
    int dec;
    exp_q.delete();
    for (int n = 0; n < N; n++) begin
      dec = (m_vm[n] * b) / 256;
      if (m_rc[n] != 0) begin
        m_rc[n] = m_rc[n] - 1;
        m_vm[n] = 0;
      end else if (dec > th) begin
        exp_q.push_back(n);
        m_vm[n] = 0;
        m_rc[n] = rl;
      end else begin
        m_vm[n] = dec;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic accum(input int idx, input int w);
    in_valid  = 1'b1;
    in_op     = 1'b0;
    in_idx    = idx[IW-1:0];
    in_weight = w[W-1:0];
    tick();
    in_valid  = 1'b0;
    m_accum(idx, w);
  endtask

  task automatic rd(input int idx, output int v);
    dbg_idx = idx[IW-1:0];
    #1;
    v = int'(dbg_vmem);
  endtask

  task automatic check_all(input string tag);
    int v;
    for (int n = 0; n < N; n++) begin
      rd(n, v);
      check($sformatf("%s_vmem%0d", tag, n), v, m_vm[n]);
    end
  endtask

  task automatic start_step(input int b, input int th, input int rl);
    beta       = b[W-1:0];
    v_th       = th[W-1:0];
    refrac_len = rl[RW-1:0];
    in_op      = 1'b1;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    m_step(b, th, rl);
    check("busy_after_step", busy, 1);
    check("in_ready_in_sweep", in_ready, 0);
    got_q.delete();
  endtask

  // Runs the sweep to step_done, then drains any pending spike.
  task automatic finish_step(input string tag, input int rdy_mode, output int lat);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      spike_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (spike_valid && spike_ready) got_q.push_back(int'(spike_idx));
      tick();
      if (step_done) begin
        lat = k;
        check({tag, "_in_ready_at_done"}, in_ready, 1);
        break;
      end
    end
    if (lat < 0) check({tag, "_step_timeout"}, 0, 1);
    spike_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (spike_valid) begin
        got_q.push_back(int'(spike_idx));
        tick();
      end
    end
    spike_ready = 1'b0;
    check({tag, "_spike_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_spike%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, lat;
    bit seen_done;
    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_idx = '0; in_weight = '0;
    beta = '0; v_th = '0; refrac_len = '0; spike_ready = 1'b0; dbg_idx = '0;
    m_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_spike_idx", spike_idx, 0);
    check("rst_step_done", step_done, 0);
    check_all("rst");

    // Test 1: back-to-back ACCUM with in_ready held high.
    in_valid = 1'b1; in_op = 1'b0; in_idx = 4'd3; in_weight = 8'h05;
    check("t1_ready0", in_ready, 1);
    tick();
    check("t1_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    m_accum(3, 5); m_accum(3, 5);
    rd(3, v); check("t1_vmem3", v, 8'h0A);

    // Test 2: saturation, floor and negative zero.
    accum(2, 8'h70); accum(2, 8'h70); accum(2, 8'h10);
    rd(2, v); check("t2_vmem2_pre", v, 8'hF0);
    accum(2, 8'h7F);
    rd(2, v); check("t2_sat", v, 8'hFF);
    accum(4, 8'h03); accum(4, 8'h85);
    rd(4, v); check("t2_floor", v, 8'h00);
    accum(3, 8'h80);
    rd(3, v); check("t2_negzero", v, 8'h0A);

    // Test 3: decay, strict threshold, latency.
    accum(0, 8'h7F); accum(1, 8'h40);
    start_step(8'h80, 8'h20, 2);
    finish_step("t3", 0, lat);
    check("t3_latency", lat + 1, N + 1);
    check("t3_first_spike", (got_q.size() > 0) ? got_q[0] : -1, 0);
    rd(0, v); check("t3_vmem0", v, 8'h00);
    rd(1, v); check("t3_vmem1", v, 8'h20);
    check_all("t3");

    // Test 4: weights discarded while refractory.
    accum(0, 8'h10);
    rd(0, v); check("t4_disc1", v, 8'h00);
    start_step(8'h80, 8'h20, 2);
    finish_step("t4a", 0, lat);
    accum(0, 8'h10);
    rd(0, v); check("t4_disc2", v, 8'h00);
    start_step(8'h80, 8'h20, 2);
    finish_step("t4b", 0, lat);
    accum(0, 8'h10);
    rd(0, v); check("t4_accept", v, 8'h10);
    check_all("t4");

    // Test 5: spike register back-pressure stalls the sweep at neuron 5.
    rst = 1'b1; tick(); rst = 1'b0; m_reset(); tick();
    accum(2, 8'h7F); accum(5, 8'h7F); accum(6, 8'h10);
    spike_ready = 1'b0;
    start_step(8'h80, 8'h20, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (step_done) seen_done = 1'b1;
    end
    check("t5_no_done", seen_done, 0);
    check("t5_held_valid", spike_valid, 1);
    check("t5_held_idx", spike_idx, 2);
    check("t5_busy", busy, 1);
    rd(5, v); check("t5_vmem5_stalled", v, 8'h7F);
    rd(6, v); check("t5_vmem6_stalled", v, 8'h10);
    finish_step("t5", 0, lat);
    check_all("t5");

    // Test 6: reset during a sweep with a spike pending.
    accum(1, 8'h7F); accum(7, 8'h33);
    spike_ready = 1'b0;
    start_step(8'h80, 8'h20, 1);
    tick(); tick(); tick(); tick();
    check("t6_busy_pre", busy, 1);
    check("t6_valid_pre", spike_valid, 1);
    rst = 1'b1;
    tick();
    m_reset();
    check("t6_valid_rst", spike_valid, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_idx_rst", spike_idx, 0);
    check_all("t6");
    rst = 1'b0;
    tick();
    check("t6_ready_rel", in_ready, 1);

    // Randomized ACCUM bursts and STEPs with random back-pressure.
    for (int r = 0; r < 12; r++) begin
      int na;
      na = int'($urandom_range(3, 14));
      for (int a = 0; a < na; a++)
        accum(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
      start_step(int'($urandom_range(64, 255)), int'($urandom_range(0, 96)),
                 int'($urandom_range(0, 3)));
      finish_step($sformatf("rnd%0d", r), 1, lat);
      check_all($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
